// File: rtl/seq_detector_param.sv
// seq_detector_param: Moore serial pattern detector with loadable pattern, KMP overlap fallback and saturating match count.
module seq_detector_param #(
  parameter int                   PATTERN_W   = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sequence_in,
  input  logic                 enable,
  input  logic                 overlap,
  input  logic                 pattern_load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 count_clear,
  output logic                 detector_out,
  output logic [CNT_W-1:0]     match_count
);
  localparam int K_W = $clog2(PATTERN_W + 1);
  // Progress k means the last k bits equal the pattern prefix, so history is rebuilt from k alone.
  function automatic logic [PATTERN_W-1:0] build(input logic [PATTERN_W-1:0] p, input logic [K_W-1:0] k, input logic b);
    build    = '0;
    build[0] = b;
    for (int i = 1; i < PATTERN_W; i++)
      if (i <= int'(k)) build[i] = p[PATTERN_W - int'(k) - 1 + i];
  endfunction
  // Longest j <= lim whose newest j bits of s equal the first j bits of p.
  function automatic logic [K_W-1:0] longest(input logic [PATTERN_W-1:0] s, input logic [PATTERN_W-1:0] p, input int lim);
    logic ok;
    longest = '0;
    for (int j = 1; j <= PATTERN_W; j++) begin
      ok = (j <= lim);
      for (int i = 0; i < j; i++) ok = ok && (s[i] == p[PATTERN_W - j + i]);
      if (ok) longest = K_W'(j);
    end
  endfunction
  logic [PATTERN_W-1:0] r_pattern;
  logic [K_W-1:0]       r_prog, w_prog_nx, w_fail, w_k, w_j;
  logic                 r_det, w_det_nx, w_match;
  logic [CNT_W-1:0]     r_count;
  assign w_fail  = longest(r_pattern, r_pattern, PATTERN_W - 1);
  // DETECT resolves its progress at the next sample so an overlap change applies without restart.
  assign w_k     = r_det ? (overlap ? w_fail : '0) : r_prog;
  assign w_j     = longest(build(r_pattern, w_k, sequence_in), r_pattern, int'(w_k) + 1);
  assign w_match = enable && !pattern_load && (w_j == K_W'(PATTERN_W));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prog <= '0;
      r_det  <= 1'b0;
    end else begin
      r_prog <= w_prog_nx;
      r_det  <= w_det_nx;
    end
  end
  always_comb begin
    w_det_nx  = pattern_load ? 1'b0 : enable ? w_match : r_det;
    w_prog_nx = pattern_load ? '0 : enable ? (w_match ? '0 : w_j) : r_prog;
  end
  always_comb begin
    detector_out = r_det;
    match_count  = r_count;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pattern <= PATTERN_RST;
    else if (pattern_load) r_pattern <= pattern_in;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_count <= '0;
    else if (count_clear) r_count <= '0;
    else if (w_match && r_count != '1) r_count <= r_count + 1'b1;
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of seq_detector_param, default instance plus a 2-bit counter instance.
module tb_seq_detector_param;
  logic       clock = 0, reset = 1, sequence_in = 0, enable = 0, overlap = 1;
  logic       pattern_load = 0, count_clear = 0;
  logic [3:0] pattern_in = 4'b0000;
  logic       det, det_s;
  logic [7:0] cnt;
  logic [1:0] cnt_s;
  int vectors = 0, miscompares = 0;

  seq_detector_param u_dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .enable(enable), .overlap(overlap),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clear(count_clear),
    .detector_out(det), .match_count(cnt));
  seq_detector_param #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .enable(enable), .overlap(overlap),
    .pattern_load(pattern_load), .pattern_in(pattern_in), .count_clear(count_clear),
    .detector_out(det_s), .match_count(cnt_s));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic exp_det, input string tag);
    sequence_in = b;
    enable      = 1;
    tick();
    check(tag, 32'(det), 32'(exp_det));
  endtask

  task automatic restart(input logic [3:0] p);
    enable       = 0;
    pattern_load = 1;
    pattern_in   = p;
    count_clear  = 1;
    tick();
    pattern_load = 0;
    count_clear  = 0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("reset_det", 32'(det), 0);
    check("reset_cnt", 32'(cnt), 0);
    reset = 0;
    repeat (2) tick();
    check("idle_det", 32'(det), 0);
    check("idle_cnt", 32'(cnt), 0);
    overlap = 1;
    bit_in(1, 0, "ov_b1"); bit_in(0, 0, "ov_b2"); bit_in(1, 0, "ov_b3"); bit_in(1, 1, "ov_b4");
    bit_in(0, 0, "ov_b5"); bit_in(1, 0, "ov_b6"); bit_in(1, 1, "ov_b7");
    check("ov_cnt", 32'(cnt), 2);
    restart(4'b1011);
    check("load_clears_det", 32'(det), 0);
    check("clear_cnt", 32'(cnt), 0);
    overlap = 0;
    bit_in(1, 0, "no_b1"); bit_in(0, 0, "no_b2"); bit_in(1, 0, "no_b3"); bit_in(1, 1, "no_b4");
    bit_in(0, 0, "no_b5"); bit_in(1, 0, "no_b6"); bit_in(1, 0, "no_b7");
    check("no_cnt", 32'(cnt), 1);
    restart(4'b1011);
    bit_in(1, 0, "cw_b1"); bit_in(0, 0, "cw_b2"); bit_in(1, 0, "cw_b3");
    count_clear = 1;
    bit_in(1, 1, "cw_det");
    count_clear = 0;
    check("clear_wins", 32'(cnt), 0);
    restart(4'b1011);
    overlap = 1;
    for (int r = 0; r < 5; r++) begin
      bit_in(1, 0, "sat_1"); bit_in(0, 0, "sat_0"); bit_in(1, 0, "sat_1b"); bit_in(1, 1, "sat_det");
    end
    check("sat_cnt", 32'(cnt_s), 3);
    check("wide_cnt", 32'(cnt), 5);
    check("sat_det_flag", 32'(det_s), 1);
    restart(4'b1011);
    bit_in(1, 0, "ld_b1"); bit_in(0, 0, "ld_b2"); bit_in(1, 0, "ld_b3");
    pattern_load = 1;
    pattern_in   = 4'b0110;
    bit_in(1, 0, "ld_strobe");
    pattern_load = 0;
    bit_in(1, 0, "ld_after1");
    bit_in(0, 0, "ld_p0"); bit_in(1, 0, "ld_p1"); bit_in(1, 0, "ld_p2"); bit_in(0, 1, "ld_det");
    check("ld_cnt", 32'(cnt), 1);
    restart(4'b1011);
    bit_in(1, 0, "hold_b1"); bit_in(0, 0, "hold_b2"); bit_in(1, 0, "hold_b3"); bit_in(1, 1, "hold_det");
    enable = 0;
    for (int c = 0; c < 4; c++) begin
      sequence_in = 1'(c);
      tick();
      check("hold_en0", 32'(det), 1);
    end
    bit_in(1, 0, "rst_b1"); bit_in(0, 0, "rst_b2"); bit_in(1, 0, "rst_b3");
    #2 reset = 1;
    #1;
    check("async_rst_det", 32'(det), 0);
    check("async_rst_cnt", 32'(cnt), 0);
    @(posedge clock);
    #1 reset = 0;
    bit_in(1, 0, "fresh_b1");
    restart(4'b0110);
    bit_in(0, 0, "prst_b0"); bit_in(1, 0, "prst_b1"); bit_in(1, 0, "prst_b2");
    #2 reset = 1;
    @(posedge clock);
    #1 reset = 0;
    bit_in(0, 0, "prst_x0");
    bit_in(1, 0, "prst_c1"); bit_in(0, 0, "prst_c2"); bit_in(1, 0, "prst_c3"); bit_in(1, 1, "prst_det");
    check("prst_cnt", 32'(cnt), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
